// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: multiply/divide opcodes, FSM states
// and a constant-width helper.
package mips_pkg;

  localparam logic [2:0] MD_MULTU = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_DIVU  = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_RUN  = 2'd1;
  localparam logic [1:0] MD_FIX  = 2'd2;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((longint'(1) << result) < longint'(value)) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Radix-2 iterative datapath: shift-add multiply or restoring divide on
// unsigned operands, one step per cycle, raw 2*WIDTH result.
module muldiv_iter_core
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               mode,    // 0 multiply, 1 divide
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   opA,     // multiplicand / dividend
  input  logic [WIDTH-1:0]   opB,     // multiplier / divisor
  output logic [2*WIDTH-1:0] result   // {HI, LO} = product or {remainder, quotient}
);

  logic [2*WIDTH-1:0] accQ;
  logic [WIDTH-1:0]   operandQ;

  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext;
  logic [WIDTH:0]     divShift;
  logic [WIDTH:0]     divDiff;
  logic [2*WIDTH-1:0] divNext;

  always_comb begin
    // Multiply: low half holds the remaining multiplier bits, high half the partial sum.
    mulSum   = {1'b0, accQ[2*WIDTH-1:WIDTH]} + (accQ[0] ? {1'b0, operandQ} : '0);
    mulNext  = {mulSum, accQ[WIDTH-1:1]};
    // Divide: high half is the running remainder, low half shifts dividend out / quotient in.
    divShift = {accQ[2*WIDTH-1:WIDTH], accQ[WIDTH-1]};
    divDiff  = divShift - {1'b0, operandQ};
    if (divDiff[WIDTH]) begin
      divNext = {divShift[WIDTH-1:0], accQ[WIDTH-2:0], 1'b0};
    end else begin
      divNext = {divDiff[WIDTH-1:0], accQ[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      accQ     <= '0;
      operandQ <= '0;
    end else if (load) begin
      accQ     <= mode ? {{WIDTH{1'b0}}, opA} : {{WIDTH{1'b0}}, opB};
      operandQ <= mode ? opB : opA;
    end else if (step) begin
      accQ     <= mode ? divNext : mulNext;
    end
  end

  assign result = accQ;

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO for the MIPS core;
// owns the control FSM, sign handling, HI/LO registers and status flags.
module mips_muldiv_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             StartE,
  input  logic [2:0]       MdOpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             Abort,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut
);

  localparam int unsigned CntW = clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic [1:0]       stateQ, stateD;
  logic [CntW-1:0]  cntQ;
  logic [WIDTH-1:0] hiQ, loQ, rawAQ;
  logic             doneQ, divZeroQ, isDivQ, negResQ, negRemQ;

  logic             accept, launch, isMulDivOp, opIsDiv, signedOp, signA, signB;
  logic [WIDTH-1:0] magA, magB;
  logic             coreMode, coreStep;
  logic [2*WIDTH-1:0] rawRes, mulRes;
  logic [WIDTH-1:0] quoFix, remFix, fixHi, fixLo;

  always_comb begin
    isMulDivOp = (MdOpE == MD_MULTU) || (MdOpE == MD_MULT) ||
                 (MdOpE == MD_DIVU) || (MdOpE == MD_DIV);
    opIsDiv    = (MdOpE == MD_DIVU) || (MdOpE == MD_DIV);
    // Abort beats a same-cycle start; requests while busy are dropped.
    accept     = (stateQ == MD_IDLE) && StartE && !Abort;
    launch     = accept && isMulDivOp;
    signedOp   = SIGNED_EN && ((MdOpE == MD_MULT) || (MdOpE == MD_DIV));
    signA      = signedOp && SrcAE[WIDTH-1];
    signB      = signedOp && SrcBE[WIDTH-1];
    magA       = signA ? -SrcAE : SrcAE;
    magB       = signB ? -SrcBE : SrcBE;
    coreMode   = launch ? opIsDiv : isDivQ;
    coreStep   = (stateQ == MD_RUN) && !Abort;
  end

  muldiv_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .CLK    (CLK),
    .Reset  (Reset),
    .mode   (coreMode),
    .load   (launch),
    .step   (coreStep),
    .opA    (magA),
    .opB    (magB),
    .result (rawRes)
  );

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      MD_IDLE: if (launch) stateD = MD_RUN;
      MD_RUN: begin
        if (Abort) begin
          stateD = MD_IDLE;
        end else if (cntQ == LastCnt) begin
          stateD = MD_FIX;
        end
      end
      MD_FIX:  stateD = MD_IDLE;
      default: stateD = MD_IDLE;
    endcase
  end

  always_comb begin
    mulRes = negResQ ? -rawRes : rawRes;
    quoFix = negResQ ? -rawRes[WIDTH-1:0] : rawRes[WIDTH-1:0];
    remFix = negRemQ ? -rawRes[2*WIDTH-1:WIDTH] : rawRes[2*WIDTH-1:WIDTH];
    if (!isDivQ) begin
      fixHi = mulRes[2*WIDTH-1:WIDTH];
      fixLo = mulRes[WIDTH-1:0];
    end else if (divZeroQ) begin
      fixHi = rawAQ;
      fixLo = '1;
    end else begin
      fixHi = remFix;
      fixLo = quoFix;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      stateQ   <= MD_IDLE;
      cntQ     <= '0;
      hiQ      <= '0;
      loQ      <= '0;
      rawAQ    <= '0;
      doneQ    <= 1'b0;
      divZeroQ <= 1'b0;
      isDivQ   <= 1'b0;
      negResQ  <= 1'b0;
      negRemQ  <= 1'b0;
    end else begin
      stateQ <= stateD;
      doneQ  <= (stateQ == MD_FIX) && !Abort;
      if (launch) begin
        cntQ     <= '0;
        isDivQ   <= opIsDiv;
        negResQ  <= signA ^ signB;
        negRemQ  <= signA;
        rawAQ    <= SrcAE;
        divZeroQ <= opIsDiv && (SrcBE == '0);
      end else if (stateQ == MD_RUN) begin
        cntQ <= cntQ + 1'b1;
      end
      if (accept && (MdOpE == MD_MTHI)) hiQ <= SrcAE;
      if (accept && (MdOpE == MD_MTLO)) loQ <= SrcAE;
      if ((stateQ == MD_FIX) && !Abort) begin
        hiQ <= fixHi;
        loQ <= fixLo;
      end
    end
  end

  assign Busy    = (stateQ != MD_IDLE);
  assign Done    = doneQ;
  assign DivZero = divZeroQ;
  assign HiOut   = hiQ;
  assign LoOut   = loQ;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit (WIDTH=32, SIGNED_EN=1): directed
// corner cases plus random ops against an arithmetic reference model.
module tb_mips_muldiv_unit;

  localparam logic [2:0] OpMultu = 3'd0;
  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpDivu  = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  logic        CLK = 1'b0;
  logic        Reset, StartE, Abort;
  logic [2:0]  MdOpE;
  logic [31:0] SrcAE, SrcBE;
  logic        Busy, Done, DivZero;
  logic [31:0] HiOut, LoOut;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;

  mips_muldiv_unit #(
    .WIDTH     (32),
    .SIGNED_EN (1'b1)
  ) dut (
    .CLK     (CLK),
    .Reset   (Reset),
    .StartE  (StartE),
    .MdOpE   (MdOpE),
    .SrcAE   (SrcAE),
    .SrcBE   (SrcBE),
    .Abort   (Abort),
    .Busy    (Busy),
    .Done    (Done),
    .DivZero (DivZero),
    .HiOut   (HiOut),
    .LoOut   (LoOut)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural results from plain integer arithmetic.
  task automatic refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo);
    longint unsigned up;
    longint          sp;
    int              sa, sb;
    sa = a;
    sb = b;
    hi = mHi;
    lo = mLo;
    case (op)
      OpMultu: begin
        up = 64'(a) * 64'(b);
        hi = up[63:32];
        lo = up[31:0];
      end
      OpMult: begin
        sp = longint'(sa) * longint'(sb);
        hi = sp[63:32];
        lo = sp[31:0];
      end
      OpDivu: begin
        if (b == 0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else begin
          hi = a % b;
          lo = a / b;
        end
      end
      OpDiv: begin
        if (b == 0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          hi = 32'h0;
          lo = 32'h8000_0000;
        end else begin
          hi = sa % sb;
          lo = sa / sb;
        end
      end
      default: ;
    endcase
  endtask

  // Launch a MUL/DIV, optionally pulse an MTLO while busy, and check timing and results.
  task automatic doOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input int pulseAt);
    logic [31:0] eHi, eLo;
    int          n, busyCnt;
    bit          isDiv;
    refModel(op, a, b, eHi, eLo);
    isDiv  = (op == OpDivu) || (op == OpDiv);
    StartE = 1'b1;
    MdOpE  = op;
    SrcAE  = a;
    SrcBE  = b;
    tick();
    StartE = 1'b0;
    MdOpE  = 3'd7;
    SrcAE  = $urandom;
    SrcBE  = $urandom;
    if (!isDiv) check("divzero_clear", {31'b0, DivZero}, 32'd0);
    n = 1;
    busyCnt = 0;
    while (!Done && n < 100) begin
      busyCnt += int'(Busy);
      if (n == pulseAt) begin
        StartE = 1'b1;
        MdOpE  = OpMtlo;
        SrcAE  = 32'hDEAD_BEEF;
      end else begin
        StartE = 1'b0;
        MdOpE  = 3'd7;
      end
      tick();
      n++;
    end
    StartE = 1'b0;
    check("done_cycle", 32'(n), 32'd34);
    check("busy_cycles", 32'(busyCnt), 32'd33);
    check("busy_at_done", {31'b0, Busy}, 32'd0);
    check("hi_result", HiOut, eHi);
    check("lo_result", LoOut, eLo);
    check("divzero", {31'b0, DivZero}, {31'b0, isDiv && (b == 0)});
    mHi = eHi;
    mLo = eLo;
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    bit          sawDone;

    Reset  = 1'b1;
    StartE = 1'b0;
    Abort  = 1'b0;
    MdOpE  = 3'd7;
    SrcAE  = '0;
    SrcBE  = '0;
    tick();
    tick();
    Reset = 1'b0;
    check("reset_hi", HiOut, 32'd0);
    check("reset_lo", LoOut, 32'd0);
    check("reset_busy", {31'b0, Busy}, 32'd0);
    check("reset_done", {31'b0, Done}, 32'd0);
    check("reset_divzero", {31'b0, DivZero}, 32'd0);

    // Directed vectors, issued back-to-back so each starts in the previous Done cycle.
    doOp(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("multu_max_hi", HiOut, 32'hFFFF_FFFE);
    check("multu_max_lo", LoOut, 32'h0000_0001);
    doOp(OpMult, 32'hFFFF_FFFD, 32'd5, 0);
    check("mult_neg_hi", HiOut, 32'hFFFF_FFFF);
    check("mult_neg_lo", LoOut, 32'hFFFF_FFF1);
    doOp(OpMult, 32'h8000_0000, 32'h8000_0000, 0);
    check("mult_minmin_hi", HiOut, 32'h4000_0000);
    check("mult_minmin_lo", LoOut, 32'h0);
    doOp(OpDiv, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_neg_lo", LoOut, 32'hFFFF_FFFD);
    check("div_neg_hi", HiOut, 32'hFFFF_FFFF);
    doOp(OpDivu, 32'd7, 32'd2, 0);
    check("divu_lo", LoOut, 32'd3);
    check("divu_hi", HiOut, 32'd1);
    doOp(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_ovf_lo", LoOut, 32'h8000_0000);
    check("div_ovf_hi", HiOut, 32'h0);
    doOp(OpDivu, 32'h1234, 32'd0, 0);
    check("divz_lo", LoOut, 32'hFFFF_FFFF);
    check("divz_hi", HiOut, 32'h1234);
    check("divz_flag", {31'b0, DivZero}, 32'd1);
    doOp(OpMultu, 32'd3, 32'd4, 0);
    check("divz_cleared", {31'b0, DivZero}, 32'd0);

    // Abort at RUN cycle 10, then MTHI.
    StartE = 1'b1;
    MdOpE  = OpMult;
    SrcAE  = 32'd12345;
    SrcBE  = 32'd678;
    tick();
    StartE = 1'b0;
    repeat (9) tick();
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    check("abort_busy", {31'b0, Busy}, 32'd0);
    sawDone = 1'b0;
    repeat (40) begin
      if (Done) sawDone = 1'b1;
      tick();
    end
    check("abort_no_done", {31'b0, sawDone}, 32'd0);
    check("abort_hi", HiOut, mHi);
    check("abort_lo", LoOut, mLo);
    StartE = 1'b1;
    MdOpE  = OpMthi;
    SrcAE  = 32'hA5A5_A5A5;
    tick();
    StartE = 1'b0;
    mHi = 32'hA5A5_A5A5;
    check("mthi_hi", HiOut, mHi);
    check("mthi_lo", LoOut, mLo);
    check("mthi_busy", {31'b0, Busy}, 32'd0);
    check("mthi_done", {31'b0, Done}, 32'd0);

    // Abort together with a start in IDLE launches nothing.
    Abort  = 1'b1;
    StartE = 1'b1;
    MdOpE  = OpMtlo;
    SrcAE  = 32'h1234_5678;
    tick();
    check("abort_mtlo_lo", LoOut, mLo);
    MdOpE = OpMultu;
    tick();
    Abort  = 1'b0;
    StartE = 1'b0;
    check("abort_start_busy", {31'b0, Busy}, 32'd0);
    StartE = 1'b1;
    MdOpE  = OpMtlo;
    SrcAE  = 32'h0BAD_F00D;
    tick();
    StartE = 1'b0;
    mLo = 32'h0BAD_F00D;
    check("mtlo_lo", LoOut, mLo);

    // Starts while busy are ignored (mid-RUN and in FIX).
    doOp(OpDivu, 32'd1000, 32'd7, 5);
    doOp(OpMult, 32'hFFFF_0000, 32'd3, 33);

    // Reset in the middle of a DIV.
    StartE = 1'b1;
    MdOpE  = OpDiv;
    SrcAE  = 32'd100;
    SrcBE  = 32'd0;
    tick();
    StartE = 1'b0;
    repeat (5) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    mHi = '0;
    mLo = '0;
    check("midreset_hi", HiOut, 32'd0);
    check("midreset_lo", LoOut, 32'd0);
    check("midreset_busy", {31'b0, Busy}, 32'd0);
    check("midreset_divzero", {31'b0, DivZero}, 32'd0);
    sawDone = 1'b0;
    repeat (40) begin
      if (Done) sawDone = 1'b1;
      tick();
    end
    check("midreset_no_done", {31'b0, sawDone}, 32'd0);

    // Random operations, biased towards the interesting corners.
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin
          ra = 32'h8000_0000;
          rb = 32'hFFFF_FFFF;
        end
        3: ra = 32'($urandom_range(0, 255));
        4: rb = -32'($urandom_range(1, 15));
        default: ;
      endcase
      doOp(rop, ra, rb, 0);
      if (i % 5 == 4) begin
        tick();
        StartE = 1'b1;
        MdOpE  = (i % 2 == 0) ? OpMthi : OpMtlo;
        SrcAE  = $urandom;
        if (MdOpE == OpMthi) mHi = SrcAE; else mLo = SrcAE;
        tick();
        StartE = 1'b0;
        check("rand_mtx_hi", HiOut, mHi);
        check("rand_mtx_lo", LoOut, mLo);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
